// File: rtl/serial_deser_pkg.sv
// Shared types and sizing helpers for the serial deserializer slice.
package serial_deser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must reach the full frame length (data bits plus optional parity bit).
  function automatic int cnt_width(input int data_width, input bit parity_en);
    return $clog2(data_width + 1 + int'(parity_en));
  endfunction

endpackage

// File: rtl/serial_deser_hold.sv
// Single-entry output holding register with valid/ready handshake and sticky overrun.
module serial_deser_hold
  import serial_deser_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_perr,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  dout_perr,
  output logic                  overrun
);

  logic slot_free;

  // A word may load if the slot is empty or is being consumed this same cycle.
  assign slot_free = !dout_valid || dout_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_perr  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load && slot_free) begin
        dout       <= load_data;
        dout_perr  <= load_perr;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (load && !slot_free) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel receiver with start framing and a held output word.
// Optional even-parity bit per word enabled by defining DESER_PARITY_EN.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sin,
  input  logic                  sin_valid,
  input  logic                  sin_start,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_perr,
  output logic                  overrun,
  output logic                  sync_err
);

`ifdef DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int FRAME_LEN = DATA_WIDTH + int'(PARITY_EN);
  localparam int CW        = cnt_width(DATA_WIDTH, PARITY_EN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic [FRAME_LEN-1:0] shift_reg, frame_next;
  logic                 last_bit, take_start, take_bit, resync, complete, frame_perr;

  assign last_bit = (cnt == LAST_IDX);
  // Bits above cnt are always zero, so OR-ing in the new bit places it at its index.
  assign frame_next = shift_reg | (FRAME_LEN'(sin) << cnt);

`ifdef DESER_PARITY_EN
  assign frame_perr = ^frame_next;
`else
  assign frame_perr = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sin_valid && sin_start) state_next = SHIFT;
      SHIFT:   if (sin_valid && !sin_start && last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    take_start = sin_valid && sin_start;
    take_bit   = (state == SHIFT) && sin_valid && !sin_start;
    resync     = (state == SHIFT) && sin_valid && sin_start;
    complete   = take_bit && last_bit;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      shift_reg <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= resync;
      if (take_start) begin
        shift_reg <= FRAME_LEN'(sin);
        cnt       <= CW'(1);
      end else if (complete) begin
        shift_reg <= '0;
        cnt       <= '0;
      end else if (take_bit) begin
        shift_reg <= frame_next;
        cnt       <= cnt + CW'(1);
      end
    end
  end

  serial_deser_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk        (clk),
    .resetn     (resetn),
    .load       (complete),
    .load_data  (frame_next[DATA_WIDTH-1:0]),
    .load_perr  (frame_perr),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_perr  (dout_perr),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized bench for serial_deserializer against a queue-based frame model.
module tb_serial_deserializer;

  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + int'(PAR);

  logic         clk = 1'b0;
  logic         resetn, sin, sin_valid, sin_start, dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid, dout_perr, overrun, sync_err;

  serial_deserializer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_perr  (dout_perr),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int n_acc = 0, n_serr = 0;
  logic [W-1:0] last_acc = '0;
  bit cmp_en = 1'b0, rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a frame is "in progress" while the bit queue is non-empty.
  bit           bits[$];
  logic [W-1:0] m_dout, m_w;
  logic         m_valid, m_perr, m_ovr, m_serr, m_done, m_p;

  initial begin
    m_dout = '0; m_valid = 0; m_perr = 0; m_ovr = 0; m_serr = 0;
  end

  always @(posedge clk) begin
    if (!resetn) begin
      bits.delete();
      m_dout = '0; m_valid = 0; m_perr = 0; m_ovr = 0; m_serr = 0;
    end else begin
      m_done = 0; m_w = '0; m_p = 0; m_serr = 0;
      if (sin_valid) begin
        if (sin_start) begin
          if (bits.size() != 0) m_serr = 1;
          bits.delete();
          bits.push_back(sin);
        end else if (bits.size() != 0) begin
          bits.push_back(sin);
          if (bits.size() == FL) begin
            m_done = 1;
            for (int i = 0; i < W; i++) m_w[i] = bits[i];
            foreach (bits[i]) m_p = m_p ^ bits[i];
            bits.delete();
          end
        end
      end
      if (m_done && (!m_valid || dout_ready)) begin
        m_dout = m_w; m_perr = PAR ? m_p : 1'b0; m_valid = 1;
      end else if (m_done) begin
        m_ovr = 1;
      end else if (m_valid && dout_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (resetn && dout_valid && dout_ready) begin
      n_acc++;
      last_acc = dout;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (sync_err === 1'b1) n_serr++;
      check("dout",       32'(dout),       32'(m_dout));
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      check("dout_perr",  32'(dout_perr),  32'(m_perr));
      check("overrun",    32'(overrun),    32'(m_ovr));
      check("sync_err",   32'(sync_err),   32'(m_serr));
    end
  end

  task automatic rr();
    if (rnd_ready) dout_ready = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sin_valid = 0; sin = 1'($urandom); sin_start = 1'($urandom); rr();
      @(negedge clk);
    end
    sin_start = 0;
  endtask

  task automatic send_bit(input logic b, input logic st, input int gapmax);
    idle($urandom_range(0, gapmax));
    sin_valid = 1; sin = b; sin_start = st; rr();
    @(negedge clk);
    sin_valid = 0; sin_start = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gapmax, input bit bad, input int ready_last);
    logic b;
    for (int i = 0; i < FL; i++) begin
      b = (i < W) ? w[i] : ((^w) ^ bad);
      if (i == FL - 1 && ready_last >= 0) dout_ready = ready_last[0];
      send_bit(b, i == 0, gapmax);
    end
  endtask

  int a0, s0, r;

  initial begin
    resetn = 0; sin = 0; sin_valid = 0; sin_start = 0; dout_ready = 1;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    resetn = 1;
    idle(2);

    // Basic word, back-to-back bits
    send_word(8'hA5, 0, 0, -1);
    check("basic_dout", 32'(dout), 32'h A5);
    check("basic_valid", 32'(dout_valid), 1);
    check("basic_overrun", 32'(overrun), 0);
    check("model_a5", 32'(m_dout), 32'hA5);

    // Stray bits in IDLE, then a gapped word
    idle(1);
    repeat (3) send_bit(1'b1, 1'b0, 1);
    send_word(8'h3C, 3, 0, -1);
    check("gapped_dout", 32'(dout), 32'h3C);
    check("gapped_valid", 32'(dout_valid), 1);
    idle(1);

    // Backpressure and overrun
    dout_ready = 0;
    send_word(8'h11, 0, 0, -1);
    send_word(8'h22, 0, 0, -1);
    check("bp_dout", 32'(dout), 32'h11);
    check("bp_overrun", 32'(overrun), 1);
    dout_ready = 1;
    idle(1);
    check("bp_drained", 32'(dout_valid), 0);
    check("bp_overrun_sticky", 32'(overrun), 1);

    // Simultaneous accept and complete
    resetn = 0; idle(1); resetn = 1;
    dout_ready = 0;
    send_word(8'h11, 0, 0, -1);
    send_word(8'h22, 0, 0, 1);
    check("sim_dout", 32'(dout), 32'h22);
    check("sim_valid", 32'(dout_valid), 1);
    check("sim_overrun", 32'(overrun), 0);
    idle(1);

    // Resync
    a0 = n_acc; s0 = n_serr;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), i == 0, 0);
    send_word(8'hF0, 0, 0, -1);
    idle(2);
    check("resync_pulses", 32'(n_serr - s0), 1);
    check("resync_words", 32'(n_acc - a0), 1);
    check("resync_word", 32'(last_acc), 32'hF0);
    check("model_f0", 32'(m_dout), 32'hF0);

    // Reset mid-word, then a word with bad parity when parity is enabled
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 0);
    resetn = 0; idle(1);
    check("midrst_dout", 32'(dout), 0);
    check("midrst_valid", 32'(dout_valid), 0);
    idle(1); resetn = 1;
    send_word(8'h81, 0, 1, -1);
    check("midrst_word", 32'(dout), 32'h81);
    check("midrst_perr", 32'(dout_perr), PAR ? 1 : 0);
    idle(2);

    // Randomized traffic
    rnd_ready = 1;
    repeat (300) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        resetn = 0; idle(1); resetn = 1;
      end else if (r <= 3) begin
        for (int i = 0; i < $urandom_range(1, FL - 1); i++)
          send_bit(1'($urandom), i == 0, 1);
      end else if (r == 4) begin
        send_bit(1'($urandom), 1'b0, 1);
      end
      send_word(W'($urandom), $urandom_range(0, 2), $urandom_range(0, 3) == 0, -1);
      idle($urandom_range(0, 2));
    end
    rnd_ready = 0; dout_ready = 1;
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
